mio_bus_resp: RTL

MIO_BUS_RESP -- requirements
Module: mio_bus_resp

---
 rtl/mio_bus_resp_if.sv | 30 +++
 rtl/mio_bus_resp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_resp_if.sv
// -----------------------------------------------------------------------------
// mio_bus_resp_if
// Purpose : CPU <-> memory-mapped I/O handshake bundle for mio_bus_resp.
// Signals :
//   CPU_MIO   - bus request from the CPU, held until MIO_ready is seen
//   mem_w     - write strobe (1 = write, 0 = read), sampled with the request
//   Addr_in   - byte address, bits [1:0] ignored by the responder
//   Data_in   - write data from the CPU
//   Data_out  - read data returned to the CPU
//   MIO_ready - access-complete handshake from the responder
// Modports: master (CPU side), slave (responder side).
// -----------------------------------------------------------------------------
interface mio_bus_resp_if;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic        MIO_ready;

  modport master (
    output CPU_MIO, mem_w, Addr_in, Data_in,
    input  Data_out, MIO_ready
  );

  modport slave (
    input  CPU_MIO, mem_w, Addr_in, Data_in,
    output Data_out, MIO_ready
  );
endinterface

// File: rtl/mio_bus_resp.sv
// -----------------------------------------------------------------------------
// mio_bus_resp
// Purpose : Memory-mapped I/O responder with programmable wait states.
//           Serves a 256x32 RAM, an 8-bit LED register, the board switches
//           and an optional free-running 32-bit counter.
// Ports   :
//   clk     - single clock, all state updates on its rising edge
//   reset   - asynchronous active-high reset
//   bus     - mio_bus_resp_if.slave (CPU_MIO, mem_w, Addr_in, Data_in,
//             Data_out, MIO_ready)
//   sw_in   - 16 board switches
//   led_out - LED register
// Parameter:
//   WAIT_CYCLES - wait states inserted before an access completes (0..15)
// Configuration macro:
//   MIO_COUNTER_EN - when defined, the CNT peripheral at 0xF000_0004 exists;
//                    otherwise that address is unmapped.
// Address map (decoded on the latched address, bits [1:0] ignored):
//   0x0000_0000-0x0000_03FF RAM, 0xE000_0000 LED, 0xF000_0000 SW (RO),
//   0xF000_0004 CNT.
// -----------------------------------------------------------------------------
module mio_bus_resp #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mio_bus_resp_if.slave        bus,
  input  logic [15:0]          sw_in,
  output logic [7:0]           led_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Word addresses (byte address >> 2) of the single-word peripherals
  localparam logic [29:0] LED_WADDR = 30'h3800_0000;
  localparam logic [29:0] SW_WADDR  = 30'h3C00_0000;
`ifdef MIO_COUNTER_EN
  localparam logic [29:0] CNT_WADDR = 30'h3C00_0001;
`endif

  state_t      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        write_q, write_d;
  logic [31:0] dout_q, dout_d;
  logic        ready_q, ready_d;
  logic [7:0]  led_q, led_d;

  logic [31:0] ram [256];
  logic        ramWe;
  logic [31:0] rdData;

  logic        isRam;
  logic        isLed;
  logic        isSw;
  logic        accessNow;

`ifdef MIO_COUNTER_EN
  logic [31:0] cnt_q, cnt_d;
  logic        isCnt;
  logic        cntWe;
`endif

  // Decode always works on the latched word address so the map is stable
  // for the whole access even if the CPU changes Addr_in meanwhile.
  assign isRam     = (addr_q[29:8] == 22'h0);
  assign isLed     = (addr_q == LED_WADDR);
  assign isSw      = (addr_q == SW_WADDR);
  // The access itself happens on the edge that leaves WAIT.
  assign accessNow = (state_q == S_WAIT) && (waitCnt_q == 4'd0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a request is only accepted from IDLE and an access
  // in progress is never aborted by CPU_MIO dropping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.CPU_MIO) state_d = S_WAIT;
      S_WAIT: if (waitCnt_q == 4'd0) state_d = S_DONE;
      S_DONE: if (!bus.CPU_MIO) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data mux for the latched address
  always_comb begin
    rdData = 32'h0;
    if (isRam) begin
      rdData = ram[addr_q[7:0]];
    end else if (isLed) begin
      rdData = {24'h0, led_q};
    end else if (isSw) begin
      rdData = {16'h0, sw_in};
`ifdef MIO_COUNTER_EN
    end else if (isCnt) begin
      rdData = cnt_q;
`endif
    end
  end

  // Output / datapath logic. MIO_ready is registered and only rises once the
  // FSM has spent a full cycle in DONE, which gives WAIT_CYCLES+2 cycles from
  // the request-sampling edge to the first MIO_ready.
  always_comb begin
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    dout_d    = dout_q;
    led_d     = led_q;
    ramWe     = 1'b0;
    ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.CPU_MIO) begin
          addr_d    = bus.Addr_in[31:2];
          data_d    = bus.Data_in;
          write_d   = bus.mem_w;
          waitCnt_d = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (waitCnt_q != 4'd0) begin
          waitCnt_d = waitCnt_q - 4'd1;
        end else if (write_q) begin
          ramWe = isRam;
          if (isLed) led_d = data_q[7:0];
        end else begin
          dout_d = rdData;
        end
      end
      S_DONE: begin
        ready_d = (state_d == S_DONE);
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt_q <= 4'd0;
      addr_q    <= 30'h0;
      data_q    <= 32'h0;
      write_q   <= 1'b0;
      dout_q    <= 32'h0;
      ready_q   <= 1'b0;
      led_q     <= 8'h0;
    end else begin
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
      led_q     <= led_d;
    end
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram[addr_q[7:0]] <= data_q;
    end
  end

`ifdef MIO_COUNTER_EN
  assign isCnt = (addr_q == CNT_WADDR);
  assign cntWe = accessNow && write_q && isCnt;

  // A bus write to CNT wins over the free-running increment that cycle.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (cntWe) cnt_d = data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.Data_out  = dout_q;
  assign bus.MIO_ready = ready_q;
  assign led_out       = led_q;

endmodule
